// File: rtl/immext_stage_pkg.sv
// Shared definitions for the immediate-extension stage: immediate format codes.
package immext_stage_pkg;

  typedef enum logic [2:0] {
    IMMSRC_ITYPE   = 3'd0,
    IMMSRC_STYPE   = 3'd1,
    IMMSRC_BTYPE   = 3'd2,
    IMMSRC_JTYPE   = 3'd3,
    IMMSRC_UTYPE   = 3'd4,
    IMMSRC_ZTYPE   = 3'd5,
    IMMSRC_SHTYPE  = 3'd6,
    IMMSRC_ILLEGAL = 3'd7
  } immsrc_e;

  localparam int IMMSRC_W = 3;

endpackage

// File: rtl/immext_stage_imm_gen.sv
// imm_gen: purely combinational RISC-V immediate decode, sign/zero-extended to XLEN.
module imm_gen
  import immext_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]         instr,
  input  logic [IMMSRC_W-1:0] immsrc,
  output logic [XLEN-1:0]     immext,
  output logic                illegal
);

  logic [31:0] raw;
  logic        signExt;

  // Build a 32-bit value first; sign formats are widened with instr[31], CSR/shift formats with zeros.
  always_comb begin
    raw     = '0;
    signExt = 1'b1;
    illegal = 1'b0;
    case (immsrc_e'(immsrc))
      IMMSRC_ITYPE:  raw = {{20{instr[31]}}, instr[31:20]};
      IMMSRC_STYPE:  raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMMSRC_BTYPE:  raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMMSRC_JTYPE:  raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMMSRC_UTYPE:  raw = {instr[31:12], 12'b0};
      IMMSRC_ZTYPE: begin
        raw     = {27'b0, instr[19:15]};
        signExt = 1'b0;
      end
      IMMSRC_SHTYPE: begin
        raw     = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
        signExt = 1'b0;
      end
      default: begin
        raw     = '0;
        illegal = 1'b1;
      end
    endcase
    immext = signExt ? XLEN'($signed(raw)) : XLEN'(raw);
  end

endmodule

// File: rtl/immext_stage.sv
// Pipelined immediate-extension stage with a 2-entry skid buffer (output + skid register).
// Optional macro IMMEXT_TARGET_EN adds in_pc/out_target (pc + immediate, buffered alongside).
module immext_stage
  import immext_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [IMMSRC_W-1:0] in_immsrc,
  input  logic [TAG_W-1:0]    in_tag,
`ifdef IMMEXT_TARGET_EN
  input  logic [XLEN-1:0]     in_pc,
  output logic [XLEN-1:0]     out_target,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_immext,
  output logic                out_illegal,
  output logic [TAG_W-1:0]    out_tag
);

  logic [XLEN-1:0]  newImm;
  logic             newIllegal;
  logic [XLEN-1:0]  newTarget;

  logic             outValid_q, outValid_d;
  logic [XLEN-1:0]  outImm_q, outImm_d;
  logic             outIllegal_q, outIllegal_d;
  logic [TAG_W-1:0] outTag_q, outTag_d;
  logic [XLEN-1:0]  outTarget_q, outTarget_d;

  logic             skidValid_q, skidValid_d;
  logic [XLEN-1:0]  skidImm_q, skidImm_d;
  logic             skidIllegal_q, skidIllegal_d;
  logic [TAG_W-1:0] skidTag_q, skidTag_d;
  logic [XLEN-1:0]  skidTarget_q, skidTarget_d;

  logic             acceptIn;
  logic             consumeOut;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr   (in_instr[31:7]),
    .immsrc  (in_immsrc),
    .immext  (newImm),
    .illegal (newIllegal)
  );

`ifdef IMMEXT_TARGET_EN
  assign newTarget = in_pc + newImm;
`else
  assign newTarget = '0;
`endif

  assign in_ready   = !skidValid_q;
  assign acceptIn   = in_valid && !skidValid_q;
  assign consumeOut = outValid_q && out_ready;

  // The skid entry is only filled when the output is held, so it always drains before new input.
  always_comb begin
    outValid_d    = outValid_q;
    outImm_d      = outImm_q;
    outIllegal_d  = outIllegal_q;
    outTag_d      = outTag_q;
    outTarget_d   = outTarget_q;
    skidValid_d   = skidValid_q;
    skidImm_d     = skidImm_q;
    skidIllegal_d = skidIllegal_q;
    skidTag_d     = skidTag_q;
    skidTarget_d  = skidTarget_q;

    if (consumeOut) begin
      if (skidValid_q) begin
        outImm_d     = skidImm_q;
        outIllegal_d = skidIllegal_q;
        outTag_d     = skidTag_q;
        outTarget_d  = skidTarget_q;
        skidValid_d  = 1'b0;
      end else if (acceptIn) begin
        outImm_d     = newImm;
        outIllegal_d = newIllegal;
        outTag_d     = in_tag;
        outTarget_d  = newTarget;
      end else begin
        outValid_d   = 1'b0;
      end
    end else if (acceptIn) begin
      if (!outValid_q) begin
        outValid_d   = 1'b1;
        outImm_d     = newImm;
        outIllegal_d = newIllegal;
        outTag_d     = in_tag;
        outTarget_d  = newTarget;
      end else begin
        skidValid_d   = 1'b1;
        skidImm_d     = newImm;
        skidIllegal_d = newIllegal;
        skidTag_d     = in_tag;
        skidTarget_d  = newTarget;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outValid_q    <= 1'b0;
      outImm_q      <= '0;
      outIllegal_q  <= 1'b0;
      outTag_q      <= '0;
      outTarget_q   <= '0;
      skidValid_q   <= 1'b0;
      skidImm_q     <= '0;
      skidIllegal_q <= 1'b0;
      skidTag_q     <= '0;
      skidTarget_q  <= '0;
    end else begin
      outValid_q    <= outValid_d;
      outImm_q      <= outImm_d;
      outIllegal_q  <= outIllegal_d;
      outTag_q      <= outTag_d;
      outTarget_q   <= outTarget_d;
      skidValid_q   <= skidValid_d;
      skidImm_q     <= skidImm_d;
      skidIllegal_q <= skidIllegal_d;
      skidTag_q     <= skidTag_d;
      skidTarget_q  <= skidTarget_d;
    end
  end

  assign out_valid   = outValid_q;
  assign out_immext  = outImm_q;
  assign out_illegal = outIllegal_q;
  assign out_tag     = outTag_q;

`ifdef IMMEXT_TARGET_EN
  assign out_target = outTarget_q;
`else
  logic unusedTarget;
  assign unusedTarget = ^{newTarget, outTarget_q};
`endif

endmodule

// File: tb/tb_immext_stage.sv
// Scoreboard bench for immext_stage: XLEN=32 and XLEN=64 instances driven by identical stimulus.
module tb_immext_stage;

  typedef struct {
    logic [63:0] imm;
    logic        ill;
    logic [3:0]  tag;
    logic [63:0] tgt;
  } expItem_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inValid = 1'b0;
  logic [31:0] inInstr = '0;
  logic [2:0]  inImmsrc = '0;
  logic [3:0]  inTag = '0;
  logic [63:0] inPc = '0;
  logic        outReady = 1'b0;
  bit          randMode = 1'b0;

  logic        rdy32, val32, ill32;
  logic [31:0] imm32, tgt32;
  logic [3:0]  tag32;
  logic        rdy64, val64, ill64;
  logic [63:0] imm64, tgt64;
  logic [3:0]  tag64;

  int checks = 0;
  int errors = 0;
  expItem_t q32[$];
  expItem_t q64[$];

  always #5 clk = ~clk;

  immext_stage #(.XLEN(32), .TAG_W(4)) dut32 (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(rdy32),
    .in_instr(inInstr), .in_immsrc(inImmsrc), .in_tag(inTag),
`ifdef IMMEXT_TARGET_EN
    .in_pc(inPc[31:0]), .out_target(tgt32),
`endif
    .out_valid(val32), .out_ready(outReady), .out_immext(imm32),
    .out_illegal(ill32), .out_tag(tag32)
  );

  immext_stage #(.XLEN(64), .TAG_W(4)) dut64 (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(rdy64),
    .in_instr(inInstr), .in_immsrc(inImmsrc), .in_tag(inTag),
`ifdef IMMEXT_TARGET_EN
    .in_pc(inPc), .out_target(tgt64),
`endif
    .out_valid(val64), .out_ready(outReady), .out_immext(imm64),
    .out_illegal(ill64), .out_tag(tag64)
  );

`ifndef IMMEXT_TARGET_EN
  assign tgt32 = '0;
  assign tgt64 = '0;
`endif

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] modelImm(input logic [31:0] ins, input logic [2:0] src, input bit is64);
    logic [63:0] r;
    case (src)
      3'd0: r = {{52{ins[31]}}, ins[31:20]};
      3'd1: r = {{52{ins[31]}}, ins[31:25], ins[11:7]};
      3'd2: r = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      3'd3: r = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      3'd4: r = {{32{ins[31]}}, ins[31:12], 12'b0};
      3'd5: r = {59'b0, ins[19:15]};
      3'd6: r = is64 ? {58'b0, ins[25:20]} : {59'b0, ins[24:20]};
      default: r = '0;
    endcase
    if (!is64) r[63:32] = '0;
    return r;
  endfunction

  function automatic expItem_t makeExp(input bit is64);
    expItem_t e;
    e.imm = modelImm(inInstr, inImmsrc, is64);
    e.ill = (inImmsrc == 3'd7);
    e.tag = inTag;
    e.tgt = inPc + e.imm;
    if (!is64) e.tgt[63:32] = '0;
    return e;
  endfunction

  // Pop on output transfer first, then push on input transfer; both sampled mid-cycle.
  always @(negedge clk) begin
    expItem_t e;
    if (!reset) begin
      if (val32 && outReady) begin
        if (q32.size() == 0) checkOutput("sb32_unexpected", 64'd1, 64'd0);
        else begin
          e = q32.pop_front();
          checkOutput("imm32", {32'b0, imm32}, e.imm);
          checkOutput("ill32", {63'b0, ill32}, {63'b0, e.ill});
          checkOutput("tag32", {60'b0, tag32}, {60'b0, e.tag});
`ifdef IMMEXT_TARGET_EN
          checkOutput("tgt32", {32'b0, tgt32}, e.tgt);
`endif
        end
      end
      if (val64 && outReady) begin
        if (q64.size() == 0) checkOutput("sb64_unexpected", 64'd1, 64'd0);
        else begin
          e = q64.pop_front();
          checkOutput("imm64", imm64, e.imm);
          checkOutput("ill64", {63'b0, ill64}, {63'b0, e.ill});
          checkOutput("tag64", {60'b0, tag64}, {60'b0, e.tag});
`ifdef IMMEXT_TARGET_EN
          checkOutput("tgt64", tgt64, e.tgt);
`endif
        end
      end
      if (inValid && rdy32) q32.push_back(makeExp(1'b0));
      if (inValid && rdy64) q64.push_back(makeExp(1'b1));
    end
  end

  // Present one item and hold it until accepted; returns aligned just after a rising edge.
  task automatic applyStimulus(input logic [31:0] ins, input logic [2:0] src, input logic [3:0] tg, input logic [63:0] pc);
    bit acc;
    bit done;
    inInstr = ins; inImmsrc = src; inTag = tg; inPc = pc; inValid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      acc = rdy32;
      @(posedge clk); #1;
      if (randMode) outReady = 1'($urandom_range(0, 1));
      if (acc) begin
        done = 1'b1;
        break;
      end
    end
    inValid = 1'b0;
    if (!done) checkOutput("accept_timeout", 64'd0, 64'd1);
    if (randMode && $urandom_range(0, 3) == 0) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #12;
    checkOutput("rst_valid", {62'b0, val32, val64}, 64'd0);
    checkOutput("rst_imm", imm64 | {32'b0, imm32}, 64'd0);
    checkOutput("rst_tag_ill", {56'b0, tag32, tag64} | {62'b0, ill32, ill64}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_ready", {62'b0, rdy32, rdy64}, 64'd3);

    outReady = 1'b1;
    applyStimulus(32'hFFF00093, 3'd0, 4'd1, 64'h0);
    checkOutput("latency", {62'b0, val32, val64}, 64'd3);
    @(negedge clk);
    checkOutput("itype_imm32", {32'b0, imm32}, 64'h0000_0000_FFFF_FFFF);
    checkOutput("itype_tag", {60'b0, tag32}, 64'd1);
    @(posedge clk); #1;

    applyStimulus(32'hFE000EE3, 3'd2, 4'd2, 64'h100);
    @(negedge clk);
    checkOutput("btype_imm32", {32'b0, imm32}, 64'h0000_0000_FFFF_FFFC);
`ifdef IMMEXT_TARGET_EN
    checkOutput("btype_tgt32", {32'b0, tgt32}, 64'h0000_0000_0000_00FC);
`endif
    @(posedge clk); #1;

    applyStimulus(32'h800000B7, 3'd4, 4'd3, 64'h0);
    @(negedge clk);
    checkOutput("utype_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    @(posedge clk); #1;
    applyStimulus(32'h03F00013, 3'd6, 4'd4, 64'h0);
    @(negedge clk);
    checkOutput("shamt_imm64", imm64, 64'd63);
    checkOutput("shamt_imm32", {32'b0, imm32}, 64'd31);
    @(posedge clk); #1;
    applyStimulus(32'h000F8073, 3'd5, 4'd5, 64'h0);
    @(negedge clk);
    checkOutput("zimm_imm64", imm64, 64'd31);
    @(posedge clk); #1;
    applyStimulus(32'hFFFFFFFF, 3'd7, 4'd6, 64'h0);
    @(negedge clk);
    checkOutput("illegal_flag", {62'b0, ill32, ill64}, 64'd3);
    checkOutput("illegal_imm", imm64, 64'd0);
    @(posedge clk); #1;
    applyStimulus(32'h00100093, 3'd0, 4'd7, 64'h0);
    @(negedge clk);
    checkOutput("legal_after", {62'b0, ill32, ill64}, 64'd0);
    @(posedge clk); #1;

    // Backpressure: tags 1,2 fill both entries, tag 3 waits.
    outReady = 1'b0;
    applyStimulus(32'h00500093, 3'd0, 4'd1, 64'h0);
    applyStimulus(32'h00600093, 3'd0, 4'd2, 64'h0);
    inInstr = 32'h00700093; inImmsrc = 3'd0; inTag = 4'd3; inValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_ready_low", {63'b0, rdy32}, 64'd0);
      checkOutput("bp_hold_tag", {60'b0, tag32}, 64'd1);
      checkOutput("bp_hold_imm", {32'b0, imm32}, 64'd5);
    end
    @(posedge clk); #1;
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("bp_out1", {59'b0, val32, tag32}, {59'b0, 1'b1, 4'd1});
    @(negedge clk);
    checkOutput("bp_out2", {59'b0, val32, tag32}, {59'b0, 1'b1, 4'd2});
    @(posedge clk); #1;
    inValid = 1'b0;
    @(negedge clk);
    checkOutput("bp_out3", {59'b0, val32, tag32}, {59'b0, 1'b1, 4'd3});
    @(posedge clk); #1;

    // Reset while both entries are full.
    outReady = 1'b0;
    applyStimulus(32'h12300093, 3'd0, 4'd8, 64'h0);
    applyStimulus(32'h45600093, 3'd0, 4'd9, 64'h0);
    checkOutput("full_ready_low", {62'b0, rdy32, rdy64}, 64'd0);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_valid", {62'b0, val32, val64}, 64'd0);
    checkOutput("async_rst_imm", imm64 | {32'b0, imm32}, 64'd0);
    q32.delete();
    q64.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    outReady = 1'b1;
    checkOutput("post_rst_ready", {62'b0, rdy32, rdy64}, 64'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("no_stale", {62'b0, val32, val64}, 64'd0);
    end
    @(posedge clk); #1;

    // Random traffic with random backpressure.
    randMode = 1'b1;
    for (int n = 0; n < 200; n++)
      applyStimulus($urandom, 3'($urandom_range(0, 7)), 4'($urandom), {$urandom, $urandom});
    randMode = 1'b0;
    outReady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (q32.size() == 0 && q64.size() == 0) break;
      @(posedge clk); #1;
    end
    checkOutput("drain", 64'(q32.size() + q64.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
